// File: rtl/gain_trim_seq.sv
// Purpose : per-channel unsigned gain trim of a magnitude frame through one shared pipelined multiplier.
// Latency : strobe in cycle 0 -> trimmed/satFlags update with trimmedStrobe in cycle NUM_GAINS+MULT_LATENCY+2.
// Backpres: none; a strobe arriving while busy is dropped and sets the sticky overrun flag.
//
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   gpioData          gain write data (low GAIN_WIDTH bits used)
//   gainStrobes       per-channel shadow gain load; top bit also requests a commit
//   gainRBK           shadow gains, zero-extended to GPIO_WIDTH each
//   overrunClear      clears the sticky overrun flag
//   strobe            frame valid pulse, magnitudes sampled with it
//   magnitudes        packed channel magnitudes, channel k at [k*MAG_WIDTH +: MAG_WIDTH]
//   busy, overrun     frame in progress / sticky dropped-frame flag
//   trimmed, satFlags results of the last completed frame, held between frames
//   trimmedStrobe     one-cycle pulse when results update; trimmedToggle flips with it
module gain_trim_seq #(
  parameter int GPIO_WIDTH   = 32,
  parameter int NUM_GAINS    = 4,
  parameter int MAG_WIDTH    = 26,
  parameter int GAIN_WIDTH   = 27,
  parameter int MULT_LATENCY = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [GPIO_WIDTH-1:0]           gpioData,
  input  logic [NUM_GAINS-1:0]            gainStrobes,
  output logic [GPIO_WIDTH*NUM_GAINS-1:0] gainRBK,
  input  logic                            overrunClear,
  input  logic                            strobe,
  input  logic [MAG_WIDTH*NUM_GAINS-1:0]  magnitudes,
  output logic                            busy,
  output logic                            overrun,
  output logic [MAG_WIDTH*NUM_GAINS-1:0]  trimmed,
  output logic [NUM_GAINS-1:0]            satFlags,
  output logic                            trimmedStrobe,
  output logic                            trimmedToggle
);

  generate
    if (NUM_GAINS < 2) begin : g_bad_num_gains
      $error("gain_trim_seq: NUM_GAINS must be at least 2");
    end
    if (GAIN_WIDTH > GPIO_WIDTH) begin : g_bad_gain_width
      $error("gain_trim_seq: GAIN_WIDTH must not exceed GPIO_WIDTH");
    end
    if (MULT_LATENCY < 1) begin : g_bad_latency
      $error("gain_trim_seq: MULT_LATENCY must be at least 1");
    end
  endgenerate

  localparam int PW = MAG_WIDTH + GAIN_WIDTH;   // full product width
  localparam int RW = PW + 1;                   // rounding sum, one guard bit so it never wraps
  localparam int CW = $clog2(NUM_GAINS);
  localparam int DW = $clog2(MULT_LATENCY + 1);

  localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = {1'b1, {(GAIN_WIDTH-1){1'b0}}};
  localparam logic [RW-1:0]         HALF_LSB = RW'(1) << (GAIN_WIDTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           issue_ch;
  logic [DW-1:0]           drain_cnt;
  logic [MAG_WIDTH-1:0]    mag_lat     [NUM_GAINS];
  logic [GAIN_WIDTH-1:0]   shadow_gain [NUM_GAINS];
  logic [GAIN_WIDTH-1:0]   shadow_nxt  [NUM_GAINS];
  logic [GAIN_WIDTH-1:0]   active_gain [NUM_GAINS];
  logic                    commit_pending;
  logic                    commit;

  // High gpioData bits are intentionally ignored.
  logic unused_gpio;
  assign unused_gpio = ^gpioData;

  // ---------------------------------------------------------------- gains
  always_comb begin
    for (int i = 0; i < NUM_GAINS; i++) begin
      shadow_nxt[i] = gainStrobes[i] ? gpioData[GAIN_WIDTH-1:0] : shadow_gain[i];
    end
  end

  always_comb begin
    gainRBK = '0;
    for (int i = 0; i < NUM_GAINS; i++) begin
      gainRBK[i*GPIO_WIDTH +: GPIO_WIDTH] = GPIO_WIDTH'(shadow_gain[i]);
    end
  end

  // Commit only between frames so a frame never mixes gain sets. The commit
  // copies shadow_nxt so a write in the commit cycle is taken along.
  assign commit = (state == S_IDLE) && commit_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_GAINS; i++) begin
        shadow_gain[i] <= GAIN_ONE;
        active_gain[i] <= GAIN_ONE;
      end
      commit_pending <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_GAINS; i++) begin
        shadow_gain[i] <= shadow_nxt[i];
        if (commit) active_gain[i] <= shadow_nxt[i];
      end
      commit_pending <= gainStrobes[NUM_GAINS-1] | (commit_pending & ~commit);
    end
  end

  // ---------------------------------------------------------- multiplier
  logic                    issue;
  logic [MAG_WIDTH-1:0]    op_mag;
  logic [GAIN_WIDTH-1:0]   op_gain;
  logic [PW-1:0]           prod_pipe [MULT_LATENCY];
  logic [CW-1:0]           ch_pipe   [MULT_LATENCY];
  logic [MULT_LATENCY-1:0] vld_pipe;

  assign issue   = (state == S_RUN);
  assign op_mag  = mag_lat[issue_ch];
  assign op_gain = active_gain[issue_ch];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | MULT_LATENCY'(issue);
    end
  end

  always_ff @(posedge clk) begin
    prod_pipe[0] <= PW'(op_mag) * PW'(op_gain);
    ch_pipe[0]   <= issue_ch;
    for (int i = 1; i < MULT_LATENCY; i++) begin
      prod_pipe[i] <= prod_pipe[i-1];
      ch_pipe[i]   <= ch_pipe[i-1];
    end
  end

  // Round half up, then clamp to the magnitude range.
  logic [RW-1:0]        rnd_sum;
  logic [RW-1:0]        rnd_shift;
  logic                 res_sat;
  logic [MAG_WIDTH-1:0] res_val;

  assign rnd_sum   = {1'b0, prod_pipe[MULT_LATENCY-1]} + HALF_LSB;
  assign rnd_shift = rnd_sum >> (GAIN_WIDTH - 1);
  assign res_sat   = |rnd_shift[RW-1:MAG_WIDTH];
  assign res_val   = res_sat ? {MAG_WIDTH{1'b1}} : rnd_shift[MAG_WIDTH-1:0];

  // Results collect here and are published together in one cycle.
  logic [MAG_WIDTH-1:0] res_buf [NUM_GAINS];
  logic [NUM_GAINS-1:0] sat_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_GAINS; i++) res_buf[i] <= '0;
      sat_buf <= '0;
    end else if (vld_pipe[MULT_LATENCY-1]) begin
      res_buf[ch_pipe[MULT_LATENCY-1]] <= res_val;
      sat_buf[ch_pipe[MULT_LATENCY-1]] <= res_sat;
    end
  end

  // ----------------------------------------------------------------- FSM
  // DRAIN lasts MULT_LATENCY+1 cycles: the pipeline plus the result buffer
  // write, so the buffer is complete when the outputs are loaded on leaving it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      issue_ch      <= '0;
      drain_cnt     <= '0;
      for (int i = 0; i < NUM_GAINS; i++) mag_lat[i] <= '0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      trimmed       <= '0;
      satFlags      <= '0;
      trimmedStrobe <= 1'b0;
      trimmedToggle <= 1'b0;
    end else begin
      trimmedStrobe <= 1'b0;

      if (strobe && (state != S_IDLE)) overrun <= 1'b1;
      else if (overrunClear)           overrun <= 1'b0;

      case (state)
        S_IDLE: begin
          if (strobe) begin
            for (int i = 0; i < NUM_GAINS; i++) begin
              mag_lat[i] <= magnitudes[i*MAG_WIDTH +: MAG_WIDTH];
            end
            issue_ch <= '0;
            busy     <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (issue_ch == CW'(NUM_GAINS - 1)) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            issue_ch <= issue_ch + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(MULT_LATENCY)) begin
            for (int i = 0; i < NUM_GAINS; i++) begin
              trimmed[i*MAG_WIDTH +: MAG_WIDTH] <= res_buf[i];
            end
            satFlags      <= sat_buf;
            trimmedStrobe <= 1'b1;
            trimmedToggle <= ~trimmedToggle;
            state         <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin  // S_DONE
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gain_trim_seq.sv
module tb_gain_trim_seq;

  localparam int GW  = 32;
  localparam int N   = 4;
  localparam int MW  = 26;
  localparam int KW  = 27;
  localparam int L   = 3;
  localparam int LAT = N + L + 2;
  localparam logic [KW-1:0] ONE = 27'h4000000;
  localparam longint unsigned MAXM = (64'd1 << MW) - 1;

  logic            clk;
  logic            rst;
  logic [GW-1:0]   gpioData;
  logic [N-1:0]    gainStrobes;
  logic [GW*N-1:0] gainRBK;
  logic            overrunClear;
  logic            strobe;
  logic [MW*N-1:0] magnitudes;
  logic            busy;
  logic            overrun;
  logic [MW*N-1:0] trimmed;
  logic [N-1:0]    satFlags;
  logic            trimmedStrobe;
  logic            trimmedToggle;

  gain_trim_seq #(
    .GPIO_WIDTH(GW), .NUM_GAINS(N), .MAG_WIDTH(MW), .GAIN_WIDTH(KW), .MULT_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .gpioData(gpioData), .gainStrobes(gainStrobes), .gainRBK(gainRBK),
    .overrunClear(overrunClear), .strobe(strobe), .magnitudes(magnitudes), .busy(busy),
    .overrun(overrun), .trimmed(trimmed), .satFlags(satFlags), .trimmedStrobe(trimmedStrobe),
    .trimmedToggle(trimmedToggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------ behavioural reference
  // Frame-level view: a frame accepted in cycle c publishes in cycle c+LAT
  // and the block is busy through that cycle.
  logic [KW-1:0] m_shadow [N];
  logic [KW-1:0] m_active [N];
  logic [KW-1:0] m_nsh    [N];
  logic [MW-1:0] m_trim   [N];
  logic [MW-1:0] m_res    [N];
  logic [N-1:0]  m_sat, m_rsat;
  bit            m_cp, m_ovr, m_pulse, m_tog, m_idle;
  int            cyc = 0;
  int            m_due = -1;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_shadow[k] = ONE; m_active[k] = ONE; m_trim[k] = '0; m_res[k] = '0;
    end
    m_sat = '0; m_rsat = '0; m_cp = 0; m_ovr = 0; m_pulse = 0; m_tog = 0; m_due = -1;
  endtask

  task automatic model_frame();
    longint unsigned p, r;
    for (int k = 0; k < N; k++) begin
      p = 64'(magnitudes[k*MW +: MW]) * 64'(m_active[k]);
      r = (p + (64'd1 << (KW - 2))) >> (KW - 1);
      if (r > MAXM) begin m_res[k] = MW'(MAXM); m_rsat[k] = 1'b1; end
      else          begin m_res[k] = MW'(r);    m_rsat[k] = 1'b0; end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      m_idle = (cyc > m_due);
      for (int k = 0; k < N; k++) m_nsh[k] = gainStrobes[k] ? gpioData[KW-1:0] : m_shadow[k];
      if (m_idle && m_cp) begin
        for (int k = 0; k < N; k++) m_active[k] = m_nsh[k];
        m_cp = 0;
      end
      if (gainStrobes[N-1]) m_cp = 1;
      for (int k = 0; k < N; k++) m_shadow[k] = m_nsh[k];
      if (strobe && m_idle) begin
        model_frame();
        m_due = cyc + LAT;
      end
      if (strobe && !m_idle)  m_ovr = 1;
      else if (overrunClear)  m_ovr = 0;
    end
    cyc++;
    m_pulse = !rst && (cyc == m_due);
    if (m_pulse) begin
      for (int k = 0; k < N; k++) m_trim[k] = m_res[k];
      m_sat = m_rsat;
      m_tog = ~m_tog;
    end
  end

  // Compare every out-of-reset cycle, away from the active edge.
  logic [127:0] e_trim, e_rbk;
  always @(negedge clk) begin
    if (!rst && cyc > 0) begin
      e_trim = '0; e_rbk = '0;
      for (int k = 0; k < N; k++) begin
        e_trim[k*MW +: MW] = m_trim[k];
        e_rbk[k*GW +: GW]  = GW'(m_shadow[k]);
      end
      check("trimmedStrobe", 128'(trimmedStrobe), 128'(m_pulse));
      check("trimmedToggle", 128'(trimmedToggle), 128'(m_tog));
      check("busy",          128'(busy),          128'(cyc <= m_due));
      check("overrun",       128'(overrun),       128'(m_ovr));
      check("trimmed",       128'(trimmed),       e_trim);
      check("satFlags",      128'(satFlags),      128'(m_sat));
      check("gainRBK",       128'(gainRBK),       e_rbk);
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_gain(input int ch, input logic [GW-1:0] val);
    gpioData    = val;
    gainStrobes = N'(1) << ch;
    tick();
    gainStrobes = '0;
  endtask

  task automatic fire(input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                      input logic [MW-1:0] m2, input logic [MW-1:0] m3);
    magnitudes = {m3, m2, m1, m0};
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  // Called in cycle 1 of a frame; returns the cycle the pulse was seen.
  task automatic wait_pulse(output int lat);
    lat = 1;
    while (!trimmedStrobe && lat < 40) begin
      tick();
      lat++;
    end
    if (lat >= 40) check("pulse_timeout", 128'(0), 128'(1));
  endtask

  int lat;
  logic [127:0] rnd;

  initial begin
    rst = 1'b1; gpioData = '0; gainStrobes = '0; overrunClear = 1'b0;
    strobe = 1'b0; magnitudes = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Post-reset: unity gains.
    check("rst_gainRBK", 128'(gainRBK), {4{32'h04000000}});
    check("rst_trimmed", 128'(trimmed), 128'(0));
    fire(26'd1000, 26'd1000, 26'd1000, 26'd1000);
    check("busy_after_strobe", 128'(busy), 128'(1));
    wait_pulse(lat);
    check("latency", 128'(lat), 128'(LAT));
    check("unity_trim", 128'(trimmed), {4{26'd1000}});
    check("unity_sat", 128'(satFlags), 128'(0));
    tick();

    // Gains 0.5, 1.0, 1.5, 0.25; commit coincides with the next strobe.
    write_gain(0, 32'h02000000);
    write_gain(1, 32'h04000000);
    write_gain(2, 32'h06000000);
    write_gain(3, 32'h01000000);
    check("rbk_written", 128'(gainRBK), {32'h01000000, 32'h06000000, 32'h04000000, 32'h02000000});
    fire(26'd1001, 26'd1001, 26'd1001, 26'd1001);
    wait_pulse(lat);
    check("round_half_up", 128'(trimmed), {26'd250, 26'd1502, 26'd1001, 26'd501});
    tick();

    // Near-2.0 gain on ch2 saturates a full-scale magnitude.
    write_gain(2, 32'h07FFFFFF);
    write_gain(3, 32'h01000000);
    tick();
    fire(26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF);
    wait_pulse(lat);
    check("sat_trim", 128'(trimmed), {26'h1000000, 26'h3FFFFFF, 26'h3FFFFFF, 26'h2000000});
    check("sat_flags", 128'(satFlags), 128'(4'b0100));
    tick();

    // Commit requested mid-frame applies only to the following frame.
    fire(26'd1000, 26'd1000, 26'd1000, 26'd1000);
    tick();
    write_gain(0, 32'h04000000);
    write_gain(3, 32'h04000000);
    wait_pulse(lat);
    check("midframe_old_gains", 128'(trimmed), {26'd250, 26'd2000, 26'd1000, 26'd500});
    tick();
    fire(26'd1000, 26'd1000, 26'd1000, 26'd1000);
    wait_pulse(lat);
    check("next_frame_new_gains", 128'(trimmed), {26'd1000, 26'd2000, 26'd1000, 26'd1000});
    tick();

    // Overrun set, clear, and set-wins-over-clear.
    fire(26'd7, 26'd7, 26'd7, 26'd7);
    strobe = 1'b1; tick(); strobe = 1'b0;
    check("overrun_set", 128'(overrun), 128'(1));
    wait_pulse(lat);
    tick();
    overrunClear = 1'b1; tick(); overrunClear = 1'b0;
    check("overrun_clear", 128'(overrun), 128'(0));
    fire(26'd9, 26'd9, 26'd9, 26'd9);
    strobe = 1'b1; overrunClear = 1'b1; tick(); strobe = 1'b0; overrunClear = 1'b0;
    check("overrun_set_wins", 128'(overrun), 128'(1));
    wait_pulse(lat);
    tick();
    overrunClear = 1'b1; tick(); overrunClear = 1'b0;

    // Reset during DRAIN aborts the frame.
    fire(26'd500, 26'd500, 26'd500, 26'd500);
    repeat (N + 2) tick();
    rst = 1'b1;
    tick(); tick();
    check("rst_mid_strobe", 128'(trimmedStrobe), 128'(0));
    check("rst_mid_trimmed", 128'(trimmed), 128'(0));
    check("rst_mid_gains", 128'(gainRBK), {4{32'h04000000}});
    check("rst_mid_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    repeat (LAT + 2) tick();
    fire(26'd1000, 26'd1000, 26'd1000, 26'd1000);
    wait_pulse(lat);
    check("post_rst_latency", 128'(lat), 128'(LAT));
    check("post_rst_trim", 128'(trimmed), {4{26'd1000}});
    tick();

    // Randomised traffic against the model.
    repeat (700) begin
      rnd          = {$urandom, $urandom, $urandom, $urandom};
      magnitudes   = rnd[MW*N-1:0];
      gpioData     = $urandom;
      gainStrobes  = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      strobe       = ($urandom_range(0, 4) == 0);
      overrunClear = ($urandom_range(0, 12) == 0);
      rst          = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0; strobe = 1'b0; gainStrobes = '0; overrunClear = 1'b0;
    repeat (LAT + 4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
